sram_arbiter_2x1: RTL

Arbitrates two sram-like masters onto one sram-like slave port: m0 is the i-cache miss path and m1 is the d-cache/uncached wrap path. The slave port is the AXI bridge's shared sram-like channel. The block replaces dedicated inst/data channels with a single shared one.
- Grants are round-robin.
- A grant is locked until the slave returns addr_ok.
- Accepted transactions are recorded in an in-order source FIFO, so each slave data_ok/rdata is routed back to the master that issued it.

---
 rtl/sram_arbiter_2x1.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sram_arbiter_2x1.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_arbiter_2x1
// Brief    : Round-robin arbiter of two sram-like masters onto one sram-like
//            slave, with an in-order source FIFO for response routing.
// Revision : 1.0  initial release
// ============================================================================
module sram_arbiter_2x1 #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    output logic        err
);

    localparam int PTR_W = $clog2(MAX_OUT);

    logic               r_lock;
    logic               r_owner;
    logic               r_last;
    logic [MAX_OUT-1:0] r_fifo;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    logic w_sel;
    logic w_full;
    logic w_empty;
    logic w_req_sel;
    logic w_s_req;
    logic w_accept;
    logic w_pop;
    logic w_head;
    logic w_live;

    assign w_full  = (r_count == CNT_W'(MAX_OUT));
    assign w_empty = (r_count == '0);

    // Lock holds the grant steady while the slave may still be sampling the payload
    always_comb begin
        w_sel = r_last;
        if (r_lock) begin
            w_sel = r_owner;
        end else if (m0_req && !m1_req) begin
            w_sel = 1'b0;
        end else if (m1_req && !m0_req) begin
            w_sel = 1'b1;
        end else if (m0_req && m1_req) begin
            w_sel = ~r_last;
        end
    end

    assign w_req_sel = w_sel ? m1_req : m0_req;
    assign w_s_req   = w_req_sel & ~w_full;
    assign w_accept  = w_s_req & s_addr_ok;
    assign w_pop     = s_data_ok & ~w_empty;
    assign w_head    = r_fifo[r_rptr];
    assign w_live    = ~rst;

    assign s_req   = w_live & w_s_req;
    assign s_wr    = w_live & (w_sel ? m1_wr : m0_wr);
    assign s_size  = w_live ? (w_sel ? m1_size  : m0_size)  : 2'b00;
    assign s_addr  = w_live ? (w_sel ? m1_addr  : m0_addr)  : 32'h0;
    assign s_wdata = w_live ? (w_sel ? m1_wdata : m0_wdata) : 32'h0;

    assign m0_addr_ok = w_live & w_accept & ~w_sel;
    assign m1_addr_ok = w_live & w_accept &  w_sel;

    assign m0_data_ok = w_live & w_pop & ~w_head;
    assign m1_data_ok = w_live & w_pop &  w_head;
    assign m0_rdata   = (w_live && !w_head) ? s_rdata : 32'h0;
    assign m1_rdata   = (w_live &&  w_head) ? s_rdata : 32'h0;

    assign err = w_live & r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock  <= 1'b0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_fifo  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lock         <= 1'b0;
                r_last         <= w_sel;
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= r_wptr + PTR_W'(1);
            end else if (w_s_req) begin
                r_lock  <= 1'b1;
                r_owner <= w_sel;
            end

            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end

            // A response with nothing outstanding is a slave protocol violation
            if (s_data_ok && w_empty) begin
                r_err <= 1'b1;
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
